ysyx_220066_ex_ctrl: RTL and testbench

Execute-stage sequencer between the ID/EX handshake and the MEM stage. It registers one decoded operation at a time and routes it either to the single-cycle combinational ALU or to the external multi-cycle multiply/divide unit. It then holds the result in a one-entry output buffer until MEM accepts it. It also handles pipeline flush, aborts in-flight mul/div operations and bounds mul/div latency with a watchdog.

---
 rtl/ysyx_220066_ex_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ysyx_220066_ex_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220066_ex_ctrl.sv
// Execute-stage sequencer: registers one decoded op, runs it on the ALU or the
// external mul/div unit, and buffers the result until MEM takes it.
module ysyx_220066_ex_ctrl #(
    parameter int MD_TIMEOUT = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_src1,
    input  logic [63:0] in_src2,
    input  logic [4:0]  in_aluctr,
    input  logic        in_md,
    input  logic [2:0]  in_mdop,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [4:0]  alu_ctr,
    input  logic [63:0] alu_result,
    output logic        md_valid,
    input  logic        md_ready,
    output logic [63:0] md_a,
    output logic [63:0] md_b,
    output logic [2:0]  md_op,
    input  logic        md_done,
    input  logic [63:0] md_result,
    output logic        md_kill,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_err,
    output logic        busy
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXE     = 3'd1;
    localparam logic [2:0] S_MD_REQ  = 3'd2;
    localparam logic [2:0] S_MD_WAIT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [7:0] WD_LIMIT  = 8'(MD_TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic [63:0] src1_q, src1_d, src2_q, src2_d;
    logic [63:0] result_q, result_d;
    logic [4:0]  aluctr_q, aluctr_d, rd_q, rd_d;
    logic [2:0]  mdop_q, mdop_d;
    logic        wen_q, wen_d, err_q, err_d, kill_q, kill_d;
    logic [7:0]  wdog_q, wdog_d, wdog_inc;
    logic        accept, timeout;

    assign in_ready = !rst && !flush &&
                      (state_q == S_IDLE || (state_q == S_DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign wdog_inc = (wdog_q == 8'hFF) ? wdog_q : wdog_q + 8'd1;
    assign timeout  = wdog_inc >= WD_LIMIT;

    always_comb begin
        state_d  = state_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        aluctr_d = aluctr_q;
        mdop_d   = mdop_q;
        rd_d     = rd_q;
        wen_d    = wen_q;
        result_d = result_q;
        err_d    = err_q;
        wdog_d   = wdog_q;
        kill_d   = 1'b0;
        if (flush) begin
            // Kill only if the MD unit actually owns an op; a coincident done retires it.
            state_d = S_IDLE;
            kill_d  = (state_q == S_MD_WAIT && !md_done) ||
                      (state_q == S_MD_REQ && md_ready);
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_EXE: begin
                    result_d = alu_result;
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end
                S_MD_REQ: begin
                    if (md_ready) begin
                        state_d = S_MD_WAIT;
                        wdog_d  = 8'd0;
                    end
                end
                S_MD_WAIT: begin
                    wdog_d = wdog_inc;
                    if (md_done) begin
                        result_d = md_result;
                        err_d    = 1'b0;
                        state_d  = S_DONE;
                    end else if (timeout) begin
                        result_d = 64'hFFFF_FFFF_FFFF_FFFF;
                        err_d    = 1'b1;
                        kill_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        // A new op may be accepted from IDLE or while DONE is being drained.
        if (accept) begin
            src1_d   = in_src1;
            src2_d   = in_src2;
            aluctr_d = in_aluctr;
            mdop_d   = in_mdop;
            rd_d     = in_rd;
            wen_d    = in_wen;
            state_d  = in_md ? S_MD_REQ : S_EXE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            src1_q   <= 64'd0;
            src2_q   <= 64'd0;
            aluctr_q <= 5'd0;
            mdop_q   <= 3'd0;
            rd_q     <= 5'd0;
            wen_q    <= 1'b0;
            result_q <= 64'd0;
            err_q    <= 1'b0;
            wdog_q   <= 8'd0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            aluctr_q <= aluctr_d;
            mdop_q   <= mdop_d;
            rd_q     <= rd_d;
            wen_q    <= wen_d;
            result_q <= result_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
            kill_q   <= kill_d;
        end
    end

    assign alu_a      = src1_q;
    assign alu_b      = src2_q;
    assign alu_ctr    = aluctr_q;
    assign md_a       = src1_q;
    assign md_b       = src2_q;
    assign md_op      = mdop_q;
    assign md_valid   = (state_q == S_MD_REQ);
    assign md_kill    = kill_q;
    assign out_valid  = (state_q == S_DONE) && !flush;
    assign out_result = result_q;
    assign out_rd     = rd_q;
    assign out_wen    = wen_q;
    assign out_err    = err_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_ysyx_220066_ex_ctrl.sv
// Directed bench for ysyx_220066_ex_ctrl: a default instance for the data paths
// and a second one with MD_TIMEOUT=4 for the watchdog.
module tb_ysyx_220066_ex_ctrl;
    logic        clk, rst, flush, inValid, inMd, inWen, mdReady, mdDone, outReady;
    logic [63:0] inSrc1, inSrc2, mdResult;
    logic [4:0]  inAluctr, inRd;
    logic [2:0]  inMdop;

    logic        inReady, mdValid, mdKill, outValid, outWen, outErr, busy;
    logic [63:0] aluA, aluB, aluResult, mdA, mdB, outResult;
    logic [4:0]  aluCtr, outRd;
    logic [2:0]  mdOp;

    logic        wInReady, wMdValid, wMdKill, wOutValid, wOutWen, wOutErr, wBusy;
    logic [63:0] wAluA, wAluB, wAluResult, wMdA, wMdB, wOutResult;
    logic [4:0]  wAluCtr, wOutRd;
    logic [2:0]  wMdOp;

    int cmpCount = 0;
    int errCount = 0;

    // Reference ALU: ctr 0 is a 64-bit add, ctr 5'b10000 is a sign-extended 32-bit add.
    function automatic logic [63:0] aluModel(input logic [63:0] a, input logic [63:0] b,
                                             input logic [4:0] ctr);
        logic [31:0] w;
        w = a[31:0] + b[31:0];
        if (ctr == 5'b10000) return {{32{w[31]}}, w};
        return a + b;
    endfunction

    assign aluResult  = aluModel(aluA, aluB, aluCtr);
    assign wAluResult = aluModel(wAluA, wAluB, wAluCtr);

    ysyx_220066_ex_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady),
        .in_src1(inSrc1), .in_src2(inSrc2), .in_aluctr(inAluctr), .in_md(inMd),
        .in_mdop(inMdop), .in_rd(inRd), .in_wen(inWen), .alu_a(aluA), .alu_b(aluB),
        .alu_ctr(aluCtr), .alu_result(aluResult), .md_valid(mdValid), .md_ready(mdReady),
        .md_a(mdA), .md_b(mdB), .md_op(mdOp), .md_done(mdDone), .md_result(mdResult),
        .md_kill(mdKill), .out_valid(outValid), .out_ready(outReady),
        .out_result(outResult), .out_rd(outRd), .out_wen(outWen), .out_err(outErr),
        .busy(busy)
    );

    ysyx_220066_ex_ctrl #(.MD_TIMEOUT(4)) dutWd (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(wInReady),
        .in_src1(inSrc1), .in_src2(inSrc2), .in_aluctr(inAluctr), .in_md(inMd),
        .in_mdop(inMdop), .in_rd(inRd), .in_wen(inWen), .alu_a(wAluA), .alu_b(wAluB),
        .alu_ctr(wAluCtr), .alu_result(wAluResult), .md_valid(wMdValid),
        .md_ready(mdReady), .md_a(wMdA), .md_b(wMdB), .md_op(wMdOp), .md_done(mdDone),
        .md_result(mdResult), .md_kill(wMdKill), .out_valid(wOutValid),
        .out_ready(outReady), .out_result(wOutResult), .out_rd(wOutRd),
        .out_wen(wOutWen), .out_err(wOutErr), .busy(wBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        cmpCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] s1, input logic [63:0] s2,
                                 input logic [4:0] ctr, input logic md, input logic [2:0] mop,
                                 input logic [4:0] rd, input logic wen);
        inValid  = v;
        inSrc1   = s1;
        inSrc2   = s2;
        inAluctr = ctr;
        inMd     = md;
        inMdop   = mop;
        inRd     = rd;
        inWen    = wen;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // Hard stop in case a stall escapes the bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [63:0] expB2b[3];
        int k, got, cyc, holdCycles, n;
        logic accepted;

        rst = 1'b1; flush = 1'b0; mdReady = 1'b0; mdDone = 1'b0; mdResult = 64'd0;
        outReady = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle; nextCycle;
        settle;
        checkOutput("rst_in_ready", inReady, 0);
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_result", outResult, 0);
        checkOutput("rst_alu_a", aluA, 0);
        checkOutput("rst_md_valid", mdValid, 0);
        checkOutput("rst_md_kill", mdKill, 0);
        rst = 1'b0;
        settle;
        checkOutput("post_rst_in_ready", inReady, 1);

        // ALU add and ADDW-style sign-extended add
        outReady = 1'b1;
        applyStimulus(1, 64'd5, 64'd7, 5'b00000, 0, 0, 5'd3, 1);
        nextCycle;
        inValid = 1'b0;
        settle;
        checkOutput("add_exe_out_valid", outValid, 0);
        checkOutput("add_alu_a", aluA, 64'd5);
        checkOutput("add_alu_b", aluB, 64'd7);
        nextCycle;
        checkOutput("add_out_valid", outValid, 1);
        checkOutput("add_result", outResult, 64'd12);
        checkOutput("add_rd", outRd, 5'd3);
        checkOutput("add_err", outErr, 0);
        nextCycle;
        checkOutput("add_out_valid_drop", outValid, 0);
        applyStimulus(1, 64'h7FFF_FFFF, 64'd1, 5'b10000, 0, 0, 5'd4, 1);
        nextCycle;
        inValid = 1'b0;
        nextCycle;
        checkOutput("addw_result", outResult, 64'hFFFF_FFFF_8000_0000);
        nextCycle;

        // Three back-to-back ALU ops, MEM stalls for 4 cycles on the first result
        expB2b[0] = 64'd11; expB2b[1] = 64'd22; expB2b[2] = 64'd33;
        k = 0; got = 0; cyc = 0; holdCycles = 0;
        applyStimulus(1, 64'd10, 64'd1, 0, 0, 0, 5'd10, 1);
        while (got < 3 && cyc < 40) begin
            outReady = !(cyc >= 2 && cyc < 6);
            settle;
            if (outValid && !outReady) begin
                holdCycles++;
                checkOutput("b2b_hold_result", outResult, expB2b[got]);
                checkOutput("b2b_hold_in_ready", inReady, 0);
            end
            if (outValid && outReady) begin
                checkOutput("b2b_result", outResult, expB2b[got]);
                checkOutput("b2b_rd", outRd, 5'(10 + got));
                got++;
            end
            accepted = inValid && inReady;
            nextCycle;
            if (accepted) begin
                k++;
                if (k < 3) applyStimulus(1, 64'(10 * (k + 1)), 64'(k + 1), 0, 0, 0, 5'(10 + k), 1);
                else inValid = 1'b0;
            end
            cyc++;
        end
        checkOutput("b2b_delivered", 64'(got), 64'd3);
        checkOutput("b2b_hold_cycles", 64'(holdCycles), 64'd4);
        outReady = 1'b1;
        nextCycle;

        // Mul/div path with a late md_ready and a slow md_done
        applyStimulus(1, 64'hAAAA, 64'h5555, 0, 1, 3'd5, 5'd7, 1);
        mdReady = 1'b0;
        nextCycle;
        inValid = 1'b0;
        settle;
        checkOutput("md_valid", mdValid, 1);
        checkOutput("md_a", mdA, 64'hAAAA);
        checkOutput("md_b", mdB, 64'h5555);
        checkOutput("md_op", mdOp, 3'd5);
        for (int i = 0; i < 2; i++) begin
            nextCycle;
            checkOutput("md_valid_hold", mdValid, 1);
            checkOutput("md_a_hold", mdA, 64'hAAAA);
        end
        mdReady = 1'b1;
        nextCycle;
        mdReady = 1'b0;
        settle;
        checkOutput("md_valid_after_hs", mdValid, 0);
        checkOutput("md_wait_busy", busy, 1);
        for (int i = 0; i < 9; i++) begin
            checkOutput("md_wait_out_valid", outValid, 0);
            nextCycle;
        end
        mdDone = 1'b1; mdResult = 64'h1234;
        nextCycle;
        mdDone = 1'b0;
        settle;
        checkOutput("md_out_valid", outValid, 1);
        checkOutput("md_result", outResult, 64'h1234);
        checkOutput("md_err", outErr, 0);
        checkOutput("md_rd", outRd, 5'd7);
        checkOutput("md_no_kill", mdKill, 0);
        nextCycle;

        // Watchdog on the MD_TIMEOUT=4 instance; md_done never comes
        rst = 1'b1;
        nextCycle;
        rst = 1'b0;
        applyStimulus(1, 64'd3, 64'd4, 0, 1, 3'd2, 5'd6, 1);
        nextCycle;
        inValid = 1'b0;
        mdReady = 1'b1;
        nextCycle;
        mdReady = 1'b0;
        settle;
        n = 0;
        while (!wOutValid && n < 20) begin
            nextCycle;
            n++;
        end
        checkOutput("wd_latency", 64'(n), 64'd4);
        checkOutput("wd_out_valid", wOutValid, 1);
        checkOutput("wd_err", wOutErr, 1);
        checkOutput("wd_result", wOutResult, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("wd_kill", wMdKill, 1);
        checkOutput("wd_kill_md_valid", wMdValid, 0);
        nextCycle;
        checkOutput("wd_kill_width", wMdKill, 0);
        applyStimulus(1, 64'd100, 64'd23, 0, 0, 0, 5'd9, 1);
        settle;
        checkOutput("wd_next_in_ready", wInReady, 1);
        nextCycle;
        inValid = 1'b0;
        nextCycle;
        checkOutput("wd_next_out_valid", wOutValid, 1);
        checkOutput("wd_next_result", wOutResult, 64'd123);
        checkOutput("wd_next_err", wOutErr, 0);

        // Flush while MD_WAIT
        rst = 1'b1;
        nextCycle;
        rst = 1'b0;
        applyStimulus(1, 64'h11, 64'h22, 0, 1, 3'd1, 5'd2, 1);
        nextCycle;
        inValid = 1'b0;
        mdReady = 1'b1;
        nextCycle;
        mdReady = 1'b0;
        flush = 1'b1;
        settle;
        checkOutput("flush_wait_in_ready", inReady, 0);
        nextCycle;
        flush = 1'b0;
        settle;
        checkOutput("flush_wait_kill", mdKill, 1);
        checkOutput("flush_wait_busy", busy, 0);
        checkOutput("flush_wait_out_valid", outValid, 0);
        nextCycle;
        checkOutput("flush_wait_kill_width", mdKill, 0);

        // Flush coinciding with md_done
        applyStimulus(1, 64'h33, 64'h44, 0, 1, 3'd1, 5'd2, 1);
        nextCycle;
        inValid = 1'b0;
        mdReady = 1'b1;
        nextCycle;
        mdReady = 1'b0;
        nextCycle;
        flush = 1'b1; mdDone = 1'b1; mdResult = 64'h99;
        nextCycle;
        flush = 1'b0; mdDone = 1'b0;
        settle;
        checkOutput("flush_done_kill", mdKill, 0);
        checkOutput("flush_done_out_valid", outValid, 0);
        checkOutput("flush_done_busy", busy, 0);
        checkOutput("flush_done_result", outResult, 64'd0);

        // Flush together with in_valid
        applyStimulus(1, 64'hDEAD, 64'h1, 0, 0, 0, 5'd1, 1);
        flush = 1'b1;
        settle;
        checkOutput("flush_in_ready", inReady, 0);
        nextCycle;
        inValid = 1'b0; flush = 1'b0;
        settle;
        checkOutput("flush_accept_busy", busy, 0);
        checkOutput("flush_accept_alu_a", aluA, 64'h33);

        // Flush in DONE with MEM stalled
        outReady = 1'b0;
        applyStimulus(1, 64'd2, 64'd3, 0, 0, 0, 5'd5, 1);
        nextCycle;
        inValid = 1'b0;
        nextCycle;
        checkOutput("flush_done_state_valid", outValid, 1);
        checkOutput("flush_done_state_result", outResult, 64'd5);
        flush = 1'b1;
        settle;
        checkOutput("flush_done_drop", outValid, 0);
        nextCycle;
        flush = 1'b0;
        settle;
        checkOutput("flush_done_idle", busy, 0);
        checkOutput("flush_done_idle_valid", outValid, 0);
        outReady = 1'b1;

        // Reset in EXE
        applyStimulus(1, 64'd8, 64'd9, 0, 0, 0, 5'd12, 1);
        nextCycle;
        inValid = 1'b0;
        rst = 1'b1;
        settle;
        checkOutput("rst_exe_in_ready", inReady, 0);
        nextCycle;
        checkOutput("rst_exe_out_valid", outValid, 0);
        checkOutput("rst_exe_busy", busy, 0);
        checkOutput("rst_exe_alu_a", aluA, 0);
        checkOutput("rst_exe_result", outResult, 0);
        checkOutput("rst_exe_rd", outRd, 0);
        checkOutput("rst_exe_wen", outWen, 0);
        rst = 1'b0;
        settle;
        checkOutput("rst_exe_in_ready_after", inReady, 1);

        // Reset in MD_REQ
        applyStimulus(1, 64'h77, 64'h88, 0, 1, 3'd6, 5'd13, 1);
        nextCycle;
        inValid = 1'b0;
        settle;
        checkOutput("rst_req_md_valid_before", mdValid, 1);
        rst = 1'b1;
        nextCycle;
        rst = 1'b0;
        settle;
        checkOutput("rst_req_md_valid", mdValid, 0);
        checkOutput("rst_req_md_a", mdA, 0);
        checkOutput("rst_req_md_op", mdOp, 0);
        checkOutput("rst_req_kill", mdKill, 0);
        checkOutput("rst_req_busy", busy, 0);
        checkOutput("rst_req_in_ready", inReady, 1);
        nextCycle;
        checkOutput("rst_req_kill_later", mdKill, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end
endmodule
